// File: rtl/spi.sv
// spi: memory-mapped SPI master (mode 0, DATA_N-bit frames, MSB first).
// Registers: CTRL=0 {EN[7], IE[6], DIV[2:0]}, DATA=1 (TX on write, last RX on read),
//            STAT=2 {OVR[2], DONE[1], BUSY[0]}, write 1 to bits 1/2 to clear.
// Ports:
//   clk, n_reset          system clock, asynchronous active-low reset
//   bus_we, bus_oe        bus write / read strobes
//   bus_data              shared tristate data bus, driven only during a selected read
//   periph_addr, periph_sel  register address and peripheral select
//   interrupt             transfer-done interrupt (DONE & IE), registered
//   cs, sck, mosi, miso   SPI pins; cs active-low, sck idles low
// Build option: define SPI_IRQ_EN to implement the IE bit and the interrupt output;
// otherwise IE reads 0 and interrupt stays 0.
module spi #(
    parameter int unsigned DATA_N   = 8,
    parameter int unsigned PERIPH_N = 4
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                bus_we,
    input  logic                bus_oe,
    inout  wire  [DATA_N-1:0]   bus_data,
    input  logic [PERIPH_N-1:0] periph_addr,
    input  logic                periph_sel,
    output logic                interrupt,
    output logic                cs,
    input  logic                miso,
    output logic                mosi,
    output logic                sck
);
    localparam int unsigned HALF_N = 2 * DATA_N;
    localparam int unsigned HALF_W = $clog2(HALF_N);
    localparam int unsigned DIV_W  = 3;

    localparam logic [PERIPH_N-1:0] ADDR_CTRL = PERIPH_N'(0);
    localparam logic [PERIPH_N-1:0] ADDR_DATA = PERIPH_N'(1);
    localparam logic [PERIPH_N-1:0] ADDR_STAT = PERIPH_N'(2);
    localparam logic [HALF_W-1:0]   HALF_LAST = HALF_W'(HALF_N - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state;
    logic                ctrl_en;
    logic                ctrl_ie;
    logic [DIV_W-1:0]    ctrl_div;
    logic [DIV_W-1:0]    div_cnt;
    logic [HALF_W-1:0]   half_cnt;
    logic [DATA_N-1:0]   tx_sr;
    logic [DATA_N-1:0]   rx_sr;
    logic [DATA_N-1:0]   rx_data;
    logic                done;
    logic                ovr;

    logic                wr_ctrl;
    logic                wr_data;
    logic                wr_stat;
    logic                rd_en;
    logic                en_nxt;
    logic                ie_nxt;
    logic                start;
    logic                tick;
    logic                abort;
    logic                finish;
    logic                done_nxt;
    logic [DATA_N-1:0]   rdata;

    // Bus decode and next-cycle flag values shared by the register block.
    always_comb begin
        wr_ctrl = periph_sel && bus_we && (periph_addr == ADDR_CTRL);
        wr_data = periph_sel && bus_we && (periph_addr == ADDR_DATA);
        wr_stat = periph_sel && bus_we && (periph_addr == ADDR_STAT);
        rd_en   = periph_sel && bus_oe && !bus_we;
        en_nxt  = wr_ctrl ? bus_data[DATA_N-1] : ctrl_en;
`ifdef SPI_IRQ_EN
        ie_nxt  = wr_ctrl ? bus_data[DATA_N-2] : ctrl_ie;
`else
        ie_nxt  = 1'b0;
`endif
        start   = wr_data && (state == IDLE) && ctrl_en;
        tick    = (state == ACTIVE) && (div_cnt == '0);
        // Clearing EN takes effect on the same edge as the CTRL write.
        abort   = (state == ACTIVE) && !en_nxt;
        finish  = tick && !abort && (half_cnt == HALF_LAST);
        done_nxt = done;
        if (start || (wr_stat && bus_data[1])) done_nxt = 1'b0;
        // Completion outranks a simultaneous clear.
        if (finish) done_nxt = 1'b1;
    end

    // Register read mux.
    always_comb begin
        rdata = '0;
        case (periph_addr)
            ADDR_CTRL: begin
                rdata[DATA_N-1]  = ctrl_en;
                rdata[DATA_N-2]  = ctrl_ie;
                rdata[DIV_W-1:0] = ctrl_div;
            end
            ADDR_DATA: rdata = rx_data;
            ADDR_STAT: begin
                rdata[0] = (state == ACTIVE);
                rdata[1] = done;
                rdata[2] = ovr;
            end
            default: rdata = '0;
        endcase
    end

    assign bus_data = rd_en ? rdata : 'z;

    // Registers, shifter and IDLE/ACTIVE sequencer.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            ctrl_en   <= 1'b0;
            ctrl_ie   <= 1'b0;
            ctrl_div  <= '0;
            div_cnt   <= '0;
            half_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            done      <= 1'b0;
            ovr       <= 1'b0;
            interrupt <= 1'b0;
            cs        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            done      <= done_nxt;
            ctrl_ie   <= ie_nxt;
            interrupt <= done_nxt && ie_nxt;
            if (wr_ctrl) begin
                ctrl_en  <= bus_data[DATA_N-1];
                ctrl_div <= bus_data[DIV_W-1:0];
            end
            if (wr_stat && bus_data[2]) ovr <= 1'b0;
            if (wr_data && (state == ACTIVE)) ovr <= 1'b1;

            case (state)
                IDLE: begin
                    if (wr_data) begin
                        tx_sr <= bus_data;
                        if (ctrl_en) begin
                            state    <= ACTIVE;
                            cs       <= 1'b0;
                            sck      <= 1'b0;
                            mosi     <= bus_data[DATA_N-1];
                            div_cnt  <= ctrl_div;
                            half_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (abort) begin
                        state <= IDLE;
                        cs    <= 1'b1;
                        sck   <= 1'b0;
                        mosi  <= 1'b0;
                    end else if (tick) begin
                        div_cnt  <= ctrl_div;
                        sck      <= !sck;
                        half_cnt <= half_cnt + 1'b1;
                        if (!sck) begin
                            rx_sr <= {rx_sr[DATA_N-2:0], miso};
                        end else if (finish) begin
                            state   <= IDLE;
                            cs      <= 1'b1;
                            mosi    <= 1'b0;
                            rx_data <= rx_sr;
                        end else begin
                            tx_sr <= tx_sr << 1;
                            mosi  <= tx_sr[DATA_N-2];
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi.sv
// tb_spi: self-checking bench for the spi peripheral. The reference model works at the
// frame level: a frame transmits TX MSB first, captures the miso bit pattern, and keeps
// cs low for 16*(DIV+1) clocks; register values follow from the register map.
module tb_spi;
    logic       clk;
    logic       n_reset;
    logic       bus_we;
    logic       bus_oe;
    wire  [7:0] bus_data;
    logic [3:0] periph_addr;
    logic       periph_sel;
    logic       interrupt;
    logic       cs;
    logic       miso;
    logic       mosi;
    logic       sck;

    logic       tb_drv;
    logic [7:0] tb_wdata;

    int n_checks;
    int n_fail;
    logic [7:0] last_rx;

    assign bus_data = tb_drv ? tb_wdata : 'z;

    spi #(.DATA_N(8), .PERIPH_N(4)) dut (
        .clk(clk), .n_reset(n_reset), .bus_we(bus_we), .bus_oe(bus_oe),
        .bus_data(bus_data), .periph_addr(periph_addr), .periph_sel(periph_sel),
        .interrupt(interrupt), .cs(cs), .miso(miso), .mosi(mosi), .sck(sck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        periph_sel = 1'b1; bus_we = 1'b1; periph_addr = addr; tb_wdata = data; tb_drv = 1'b1;
        @(negedge clk);
        periph_sel = 1'b0; bus_we = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [7:0] data);
        @(negedge clk);
        periph_sel = 1'b1; bus_oe = 1'b1; periph_addr = addr;
        #1 data = bus_data;
        periph_sel = 1'b0; bus_oe = 1'b0;
    endtask

    // Starts a frame by writing DATA and observes it until cs returns high.
    task automatic do_frame(input logic [7:0] tx, input logic [7:0] rxpat,
                            input bit ovr_wr, input logic [7:0] ovr_val,
                            output int cs_low, output logic [7:0] mosi_byte,
                            output int rises, output logic [7:0] stat_mid,
                            output bit timeout);
        logic prev_sck;
        miso = rxpat[7];
        bus_write(4'd1, tx);
        cs_low = 0; rises = 0; mosi_byte = 8'h00; prev_sck = 1'b0;
        stat_mid = 8'hEE; timeout = 1'b1;
        for (int i = 0; i < 600; i++) begin
            periph_sel = 1'b0; bus_we = 1'b0; tb_drv = 1'b0;
            if (cs) begin
                timeout = 1'b0;
                break;
            end
            cs_low++;
            if (sck && !prev_sck) begin
                mosi_byte = {mosi_byte[6:0], mosi};
                rises++;
                if (rises < 8) miso = rxpat[7 - rises];
            end
            prev_sck = sck;
            if (i == 2 && ovr_wr) begin
                periph_sel = 1'b1; bus_we = 1'b1; periph_addr = 4'd1;
                tb_wdata = ovr_val; tb_drv = 1'b1;
            end
            if (i == 3) begin
                periph_sel = 1'b1; bus_oe = 1'b1; periph_addr = 4'd2;
                #1 stat_mid = bus_data;
                periph_sel = 1'b0; bus_oe = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [7:0] got;
        @(negedge clk); n_reset = 1'b0;
        @(negedge clk); n_reset = 1'b1;
        n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", cs); end
        n_checks++; if (sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", sck); end
        n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", interrupt); end
        for (int a = 0; a < 3; a++) begin
            bus_read(4'(a), got);
            n_checks++;
            if (got !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 00", a, got); end
        end
    endtask

    task automatic test_tristate;
        logic [7:0] got;
        bus_write(4'd0, 8'h81);
        @(negedge clk);
        tb_wdata = 8'h00; tb_drv = 1'b1; periph_addr = 4'd0;
        periph_sel = 1'b0; bus_oe = 1'b1;
        #1 n_checks++;
        if (bus_data !== 8'h00) begin n_fail++; $display("FAIL z_nosel: got %h want 00", bus_data); end
        periph_sel = 1'b1; bus_oe = 1'b0;
        #1 n_checks++;
        if (bus_data !== 8'h00) begin n_fail++; $display("FAIL z_nooe: got %h want 00", bus_data); end
        periph_sel = 1'b0; tb_drv = 1'b0;
        bus_write(4'd5, 8'hFF);
        bus_read(4'd5, got);
        n_checks++; if (got !== 8'h00) begin n_fail++; $display("FAIL unmapped_rd: got %h want 00", got); end
        bus_read(4'd0, got);
        n_checks++; if (got !== 8'h81) begin n_fail++; $display("FAIL ctrl_rd: got %h want 81", got); end
    endtask

    task automatic test_transfer;
        logic [7:0] got, mb, sm, tx, rx, div;
        int cl, rs;
        bit to;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                div = 8'd1; tx = 8'hAC; rx = 8'hFF;
            end else begin
                div = 8'($urandom_range(0, 7)); tx = 8'($urandom); rx = 8'($urandom);
            end
            bus_write(4'd0, 8'h80 | div);
            do_frame(tx, rx, 1'b0, 8'h00, cl, mb, rs, sm, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL xfer%0d_timeout: cs stuck low", k); end
            n_checks++;
            if (cl != 16 * (int'(div) + 1)) begin n_fail++; $display("FAIL xfer%0d_cs_len: got %0d want %0d", k, cl, 16 * (int'(div) + 1)); end
            n_checks++; if (mb !== tx || rs != 8) begin n_fail++; $display("FAIL xfer%0d_mosi: got %h (%0d rises) want %h (8)", k, mb, rs, tx); end
            n_checks++; if (sm !== 8'h01) begin n_fail++; $display("FAIL xfer%0d_stat_busy: got %h want 01", k, sm); end
            bus_read(4'd1, got);
            n_checks++; if (got !== rx) begin n_fail++; $display("FAIL xfer%0d_rx: got %h want %h", k, got, rx); end
            bus_read(4'd2, got);
            n_checks++; if (got !== 8'h02) begin n_fail++; $display("FAIL xfer%0d_stat: got %h want 02", k, got); end
            last_rx = rx;
        end
    endtask

    task automatic test_disabled;
        logic [7:0] got;
        bus_write(4'd2, 8'h06);
        bus_write(4'd0, 8'h00);
        bus_write(4'd1, 8'h3C);
        repeat (4) @(negedge clk);
        n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL dis_cs: got %b want 1", cs); end
        bus_read(4'd2, got);
        n_checks++; if (got !== 8'h00) begin n_fail++; $display("FAIL dis_stat: got %h want 00", got); end
    endtask

    task automatic test_irq;
        logic [7:0] got, mb, sm;
        int cl, rs;
        bit to;
        bus_write(4'd0, 8'hC0);
        bus_read(4'd0, got);
`ifdef SPI_IRQ_EN
        n_checks++; if (got !== 8'hC0) begin n_fail++; $display("FAIL irq_ctrl: got %h want c0", got); end
`else
        n_checks++; if (got !== 8'h80) begin n_fail++; $display("FAIL irq_ctrl: got %h want 80", got); end
`endif
        do_frame(8'h55, 8'h00, 1'b0, 8'h00, cl, mb, rs, sm, to);
        n_checks++; if (to || mb !== 8'h55) begin n_fail++; $display("FAIL irq_frame: got %h timeout %b want 55", mb, to); end
`ifdef SPI_IRQ_EN
        n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", interrupt); end
`else
        n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_tied: got %b want 0", interrupt); end
`endif
        bus_read(4'd1, got);
        n_checks++; if (got !== 8'h00) begin n_fail++; $display("FAIL irq_rx: got %h want 00", got); end
        bus_write(4'd2, 8'h02);
        n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %b want 0", interrupt); end
        bus_read(4'd2, got);
        n_checks++; if (got !== 8'h00) begin n_fail++; $display("FAIL irq_stat: got %h want 00", got); end
        last_rx = 8'h00;
    endtask

    task automatic test_overrun;
        logic [7:0] got, mb, sm, tx, rx;
        int cl, rs;
        bit to;
        tx = 8'($urandom); rx = 8'($urandom);
        bus_write(4'd0, 8'h80);
        do_frame(tx, rx, 1'b1, ~tx, cl, mb, rs, sm, to);
        n_checks++; if (sm !== 8'h05) begin n_fail++; $display("FAIL ovr_stat_mid: got %h want 05", sm); end
        n_checks++; if (to || mb !== tx || cl != 16) begin n_fail++; $display("FAIL ovr_frame: got %h len %0d want %h len 16", mb, cl, tx); end
        bus_read(4'd1, got);
        n_checks++; if (got !== rx) begin n_fail++; $display("FAIL ovr_rx: got %h want %h", got, rx); end
        bus_read(4'd2, got);
        n_checks++; if (got !== 8'h06) begin n_fail++; $display("FAIL ovr_stat_end: got %h want 06", got); end
        bus_write(4'd2, 8'h04);
        bus_read(4'd2, got);
        n_checks++; if (got !== 8'h02) begin n_fail++; $display("FAIL ovr_clr: got %h want 02", got); end
        last_rx = rx;
    endtask

    task automatic test_abort;
        logic [7:0] got;
        bus_write(4'd0, 8'h83);
        miso = 1'b1;
        bus_write(4'd1, 8'hA5);
        repeat (10) @(negedge clk);
        bus_write(4'd0, 8'h00);
        n_checks++; if (cs !== 1'b1 || sck !== 1'b0) begin n_fail++; $display("FAIL abort_pins: cs %b sck %b want 1 0", cs, sck); end
        bus_read(4'd2, got);
        n_checks++; if (got !== 8'h00) begin n_fail++; $display("FAIL abort_stat: got %h want 00", got); end
        repeat (70) @(negedge clk);
        n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL abort_late_cs: got %b want 1", cs); end
        bus_read(4'd1, got);
        n_checks++; if (got !== last_rx) begin n_fail++; $display("FAIL abort_rx: got %h want %h", got, last_rx); end
        bus_read(4'd2, got);
        n_checks++; if (got !== 8'h00) begin n_fail++; $display("FAIL abort_late_stat: got %h want 00", got); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] got;
        bus_write(4'd0, 8'h80);
        bus_write(4'd1, 8'hFF);
        repeat (3) @(negedge clk);
        #2 n_reset = 1'b0;
        #1 n_checks++;
        if (cs !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_pins: cs %b sck %b mosi %b want 1 0 0", cs, sck, mosi);
        end
        @(negedge clk); n_reset = 1'b1;
        for (int a = 0; a < 3; a++) begin
            bus_read(4'(a), got);
            n_checks++;
            if (got !== 8'h00) begin n_fail++; $display("FAIL rst_mid_reg%0d: got %h want 00", a, got); end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; last_rx = 8'h00;
        n_reset = 1'b0; bus_we = 1'b0; bus_oe = 1'b0; periph_addr = 4'd0;
        periph_sel = 1'b0; miso = 1'b0; tb_drv = 1'b0; tb_wdata = 8'h00;
        test_reset;
        test_tristate;
        test_transfer;
        test_disabled;
        test_irq;
        test_overrun;
        test_abort;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
